// File: rtl/mac_pkg.sv
// Shared types and default sizing for the MAC sequencing controller.
package mac_pkg;

  localparam int MAC_DATA_WIDTH = 8;
  localparam int MAC_NUM_MAC    = 8;
  localparam int MAC_VEC_LEN    = 8;

  // Element counter must be able to hold VEC_LEN itself.
  function automatic int cnt_width(input int vec_len);
    return $clog2(vec_len + 1);
  endfunction

  localparam int CNT_W = cnt_width(MAC_VEC_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_WAIT_FULL,
    S_RUN,
    S_DRAIN,
    S_DONE
  } mac_seq_state_t;

endpackage

// File: rtl/mac_seq_ctrl_if.sv
// Host/FIFO/MAC-array strobe bundle for mac_seq_ctrl; master = controller side.
interface mac_seq_ctrl_if
  import mac_pkg::*;
#(
  parameter int NUM_MAC = MAC_NUM_MAC
);

  logic               start;
  logic               a_full;
  logic [NUM_MAC-1:0] b_full;
  logic               a_rden;
  logic [NUM_MAC-1:0] b_rden;
  logic               mac_clr;
  logic [NUM_MAC-1:0] mac_en;
  logic               busy;
  logic               done;

  modport master (
    input  start, a_full, b_full,
    output a_rden, b_rden, mac_clr, mac_en, busy, done
  );

  modport slave (
    output start, a_full, b_full,
    input  a_rden, b_rden, mac_clr, mac_en, busy, done
  );

endinterface

// File: rtl/mac_en_skew.sv
// Per-row delay line turning the row-0 read strobe into b_rden/mac_en.
// Row i is delayed i extra cycles when MAC_SEQ_CTRL_SKEW_EN is defined.
module mac_en_skew
  import mac_pkg::*;
#(
  parameter int NUM_MAC = MAC_NUM_MAC
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               strobe,
  output logic [NUM_MAC-1:0] b_rden,
  output logic [NUM_MAC-1:0] mac_en,
  output logic               pending
);

`ifdef MAC_SEQ_CTRL_SKEW_EN
  localparam bit SKEW = 1'b1;
`else
  localparam bit SKEW = 1'b0;
`endif

  logic [NUM_MAC-1:0] row_pending;

  for (genvar i = 0; i < NUM_MAC; i++) begin : g_row
    localparam int DEPTH = SKEW ? i : 0;

    // chain[DEPTH-1] is the delayed read strobe, chain[DEPTH] the enable one cycle later.
    logic [DEPTH:0] chain;

    if (DEPTH == 0) begin : g_direct
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) chain <= '0;
        else        chain <= strobe;
      end
      assign b_rden[i]      = strobe;
      assign row_pending[i] = 1'b0;
    end else begin : g_delay
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) chain <= '0;
        else        chain <= {chain[DEPTH-1:0], strobe};
      end
      assign b_rden[i]      = chain[DEPTH-1];
      assign row_pending[i] = |chain[DEPTH-1:0];
    end

    assign mac_en[i] = chain[DEPTH];
  end

  // Set while any enable is still to appear after the current cycle.
  assign pending = |row_pending;

endmodule

// File: rtl/mac_seq_ctrl.sv
// Sequencing controller for the matrix-vector MAC array: clear, wait for full
// FIFOs, stream VEC_LEN operand pairs, drain, pulse done. Optional systolic
// row skew via MAC_SEQ_CTRL_SKEW_EN.
module mac_seq_ctrl
  import mac_pkg::*;
#(
  parameter int DATA_WIDTH = MAC_DATA_WIDTH,
  parameter int NUM_MAC    = MAC_NUM_MAC,
  parameter int VEC_LEN    = MAC_VEC_LEN
) (
  input  logic           clk,
  input  logic           rst_n,
  mac_seq_ctrl_if.master bus
);

  localparam int CW = cnt_width(VEC_LEN);
  localparam logic [CW-1:0] LAST = CW'(VEC_LEN - 1);

  if (DATA_WIDTH < 1 || NUM_MAC < 1 || VEC_LEN < 1) begin : g_bad_param
    $error("mac_seq_ctrl: DATA_WIDTH, NUM_MAC and VEC_LEN must all be positive");
  end

  mac_seq_state_t state, state_next;
  logic [CW-1:0]  cnt, cnt_next;
  logic           run;
  logic           pending;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    run         = 1'b0;
    bus.a_rden  = 1'b0;
    bus.mac_clr = 1'b0;
    bus.busy    = 1'b1;
    bus.done    = 1'b0;

    case (state)
      S_IDLE: begin
        bus.busy = 1'b0;
        if (bus.start) state_next = S_CLEAR;
      end
      S_CLEAR: begin
        bus.mac_clr = 1'b1;
        cnt_next    = '0;
        state_next  = S_WAIT_FULL;
      end
      S_WAIT_FULL: begin
        if (bus.a_full && (&bus.b_full)) state_next = S_RUN;
      end
      S_RUN: begin
        run        = 1'b1;
        bus.a_rden = 1'b1;
        cnt_next   = cnt + 1'b1;
        if (cnt == LAST) state_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (!pending) state_next = S_DONE;
      end
      S_DONE: begin
        bus.done   = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  mac_en_skew #(
    .NUM_MAC (NUM_MAC)
  ) u_skew (
    .clk     (clk),
    .rst_n   (rst_n),
    .strobe  (run),
    .b_rden  (bus.b_rden),
    .mac_en  (bus.mac_en),
    .pending (pending)
  );

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Self-checking bench for mac_seq_ctrl with an operand FIFO/MAC array harness.
module tb_mac_seq_ctrl;
  import mac_pkg::*;

  localparam int NM = 8;
  localparam int VL = 8;
  localparam int DW = 8;
`ifdef MAC_SEQ_CTRL_SKEW_EN
  localparam bit SKEW = 1'b1;
`else
  localparam bit SKEW = 1'b0;
`endif
  localparam int DRAIN_LEN = SKEW ? NM : 1;
  localparam int OW = 2 * NM + 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mac_seq_ctrl_if #(.NUM_MAC(NM)) bus ();

  mac_seq_ctrl #(
    .DATA_WIDTH (DW),
    .NUM_MAC    (NM),
    .VEC_LEN    (VL)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Environment: FIFOs with one-cycle read latency and a MAC array.
  logic [DW-1:0] amem [VL];
  logic [DW-1:0] bmem [NM][VL];
  int            aptr;
  int            bptr [NM];
  logic [DW-1:0] a_hist [NM];
  logic [DW-1:0] b_q [NM];
  logic [31:0]   acc [NM];
  logic [31:0]   exp_acc [NM];

  always @(posedge clk) begin
    if (bus.mac_clr) begin
      aptr <= 0;
      for (int i = 0; i < NM; i++) bptr[i] <= 0;
    end else begin
      if (bus.a_rden && aptr < VL) begin
        a_hist[0] <= amem[aptr];
        aptr      <= aptr + 1;
      end
      for (int i = 0; i < NM; i++)
        if (bus.b_rden[i] && bptr[i] < VL) begin
          b_q[i]  <= bmem[i][bptr[i]];
          bptr[i] <= bptr[i] + 1;
        end
    end
    for (int k = 1; k < NM; k++) a_hist[k] <= a_hist[k-1];
    for (int i = 0; i < NM; i++) begin
      if (bus.mac_clr)        acc[i] <= '0;
      else if (bus.mac_en[i]) acc[i] <= acc[i] + 32'(a_hist[SKEW ? i : 0]) * 32'(b_q[i]);
    end
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input int cyc, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", name, cyc, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [OW-1:0] outs();
    return {bus.busy, bus.done, bus.mac_clr, bus.a_rden, bus.b_rden, bus.mac_en};
  endfunction

  // Expected strobes as interval membership, cycle 0 = start sampled.
  function automatic logic [OW-1:0] exp_outs(input int c, input int r, input int d);
    logic [NM-1:0] brd, men;
    int off;
    for (int i = 0; i < NM; i++) begin
      off    = SKEW ? i : 0;
      brd[i] = (c >= r + off) && (c < r + off + VL);
      men[i] = (c >= r + off + 1) && (c < r + off + 1 + VL);
    end
    return {(c >= 1 && c <= d), (c == d), (c == 1), (c >= r && c < r + VL), brd, men};
  endfunction

  task automatic load(input bit pattern);
    for (int i = 0; i < NM; i++) exp_acc[i] = '0;
    for (int k = 0; k < VL; k++) begin
      amem[k] = pattern ? DW'(k + 1) : DW'($urandom);
      for (int i = 0; i < NM; i++) begin
        bmem[i][k] = pattern ? DW'(i + 1) : DW'($urandom);
        exp_acc[i] += 32'(amem[k]) * 32'(bmem[i][k]);
      end
    end
  endtask

  task automatic drive_flags(input int c, input int f, input int x, input bit flaky, input int r);
    if (flaky && c >= r) begin
      bus.a_full = 1'($urandom);
      bus.b_full = NM'($urandom);
    end else begin
      bus.a_full = (c >= f);
      bus.b_full = {(c >= f + x), {(NM-1){(c >= f)}}};
    end
  endtask

  // Entered in the cycle where start is to be sampled; returns in cycle d+1.
  task automatic run_pass(input int f, input int x, input bit pulse, input bit hold,
                          input bit pattern, input bit flaky, input int r, input int d);
    int men_cnt [NM];
    for (int i = 0; i < NM; i++) men_cnt[i] = 0;
    load(pattern);
    for (int c = 0; c <= d + 1; c++) begin
      if (c > 0) step();
      if (c == 0)      bus.start = 1'b1;
      else if (c >= d) bus.start = hold;
      else             bus.start = pulse ? 1'($urandom_range(0, 1)) : 1'b0;
      drive_flags(c, f, x, flaky, r);
      check("strobes", c, 64'(outs()), 64'(exp_outs(c, r, d)));
      for (int i = 0; i < NM; i++) men_cnt[i] += int'(bus.mac_en[i]);
      if (c == d)
        for (int i = 0; i < NM; i++) check($sformatf("cout_row%0d", i), c, 64'(acc[i]), 64'(exp_acc[i]));
    end
    for (int i = 0; i < NM; i++) check($sformatf("en_count_row%0d", i), d + 1, 64'(men_cnt[i]), 64'(VL));
  endtask

  typedef struct {
    int f;
    int x;
    bit pulse;
    bit hold;
    bit pattern;
    int exp_run;
    int exp_done;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int f, x, r, d;
    tbl[0] = '{0, 0, 1'b0, 1'b0, 1'b1, 3, 12};
    tbl[1] = '{0, 0, 1'b1, 1'b1, 1'b1, 3, 12};
    tbl[2] = '{0, 0, 1'b0, 1'b0, 1'b1, 3, 12};
    tbl[3] = '{2, 5, 1'b0, 1'b0, 1'b0, 8, 17};
    tbl[4] = '{4, 0, 1'b0, 1'b0, 1'b0, 5, 14};
    tbl[5] = '{3, 2, 1'b1, 1'b0, 1'b1, 6, 15};
    for (int t = 0; t < 6; t++) tbl[t].exp_done += SKEW ? NM - 1 : 0;

    // Reset held with start and full flags asserted.
    bus.start  = 1'b1;
    bus.a_full = 1'b1;
    bus.b_full = '1;
    repeat (3) step();
    check("reset_outputs", 0, 64'(outs()), 64'd0);
    rst_n = 1'b1;

    for (int t = 0; t < 6; t++)
      run_pass(tbl[t].f, tbl[t].x, tbl[t].pulse, tbl[t].hold, tbl[t].pattern, 1'b0,
               tbl[t].exp_run, tbl[t].exp_done);

    // Asynchronous reset in RUN with four elements already read.
    load(1'b1);
    for (int c = 0; c <= 7; c++) begin
      if (c > 0) step();
      bus.start = (c == 0);
      drive_flags(c, 0, 0, 1'b0, 3);
      check("pre_reset", c, 64'(outs()), 64'(exp_outs(c, 3, 3 + VL + DRAIN_LEN)));
    end
    rst_n = 1'b0;
    #1;
    check("async_reset", 7, 64'(outs()), 64'd0);
    step();
    check("reset_hold", 8, 64'(outs()), 64'd0);
    rst_n = 1'b1;
    step();
    check("post_reset_idle", 9, 64'(outs()), 64'd0);
    run_pass(0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 3, 3 + VL + DRAIN_LEN);

    // Random fill timing, stray start pulses, flag drops during RUN, random data.
    for (int n = 0; n < 20; n++) begin
      f = $urandom_range(0, 6);
      x = $urandom_range(0, 4);
      r = ((f + x) > 2 ? (f + x) : 2) + 1;
      d = r + VL + DRAIN_LEN;
      run_pass(f, x, 1'($urandom), 1'($urandom), 1'b0, 1'($urandom), r, d);
    end
    bus.start = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mac_seq_ctrl.md
# mac_seq_ctrl

Sequencing controller for the matrix-vector MAC array. On a start request it clears all MAC accumulators, waits for the operand FIFOs to fill, and streams VEC_LEN operand pairs from the FIFOs into NUM_MAC MAC units with correctly aligned enables. When the final product has accumulated it pulses done. It sits between the host/FIFO-fill logic and the MAC array, and owns every En/Clr/rden strobe in the datapath.

## Interface
- DATA_WIDTH, 8: operand width; passed through for result sizing only
- NUM_MAC, 8: number of MAC units (matrix rows)
- VEC_LEN, 8: elements per dot product (FIFO depth)
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  reset; asynchronous, active-low
- start  in  1  level-sampled request; acted on only in IDLE
- a_full  in  1  A-vector FIFO holds VEC_LEN entries
- b_full  in  NUM_MAC  per-row B FIFO holds VEC_LEN entries
- a_rden  out  1  A FIFO read strobe; data valid the following cycle
- b_rden  out  NUM_MAC  per-row B FIFO read strobes
- mac_clr  out  1  synchronous clear to all MACs
- mac_en  out  NUM_MAC  per-MAC accumulate enable
- busy  out  1  high in every state except IDLE
- done  out  1  single-cycle completion pulse

## Operation
- Reset values: all outputs 0, state IDLE, element counter 0, enable pipeline cleared.
- States: IDLE, CLEAR, WAIT_FULL, RUN, DRAIN, DONE.
- IDLE -> CLEAR when start=1. start is ignored in every other state.
- CLEAR, exactly 1 cycle: mac_clr=1 -> WAIT_FULL.
- WAIT_FULL: hold until a_full=1 and &b_full=1, then -> RUN. No timeout.
- RUN, exactly VEC_LEN cycles: a_rden=1 and b_rden=all-ones. Counter is $clog2(VEC_LEN+1) bits, increments on each read, and leaves RUN at count VEC_LEN-1.
- mac_en is b_rden delayed by 1 register to match FIFO read latency. mac_en and mac_clr are never high in the same cycle.
- DRAIN: no reads issued. Stays until the enable pipeline is empty: 1 cycle, or NUM_MAC cycles with skew. Then -> DONE.
- DONE, 1 cycle: done=1 -> IDLE. Cout values on the MACs are final from this cycle on, and stay final until the next CLEAR.
- start held high through DONE starts a new pass: IDLE is entered, then CLEAR follows on the next edge.
- If FIFO full flags drop during RUN, the drop is ignored. The upstream FIFOs guarantee no underflow.
- rst_n asserted mid-pass: immediate return to reset values. MAC contents are undefined to the controller; the next pass re-clears them.

## Timing
- start sampled at edge 0 -> mac_clr high in cycle 1.
- With FIFOs already full: RUN occupies cycles 3..VEC_LEN+2.
- mac_en high cycles 4..VEC_LEN+3.
- Without skew: done in cycle VEC_LEN+4. Total start-to-done latency is VEC_LEN+4 cycles.
- busy rises in cycle 1 and falls when done falls.

## Configuration
- MAC_SEQ_CTRL_SKEW_EN defined: systolic skew.
  - b_rden[i] and mac_en[i] are delayed i additional cycles relative to row 0.
  - a_rden is unchanged.
  - DRAIN lasts NUM_MAC cycles; done arrives at VEC_LEN+NUM_MAC+3.
- Undefined: all rows are strobed in lockstep; DRAIN lasts 1 cycle.

## Structure
- Package mac_pkg holds:
  - the state enum mac_seq_state_t;
  - defaults DATA_WIDTH/NUM_MAC/VEC_LEN;
  - localparam CNT_W.
- Sub-module mac_en_skew: a per-row shift-register delay line. It produces b_rden/mac_en from a single row-0 strobe, and its depth is selected by MAC_SEQ_CTRL_SKEW_EN.

## Test plan
- Reset with start=1 and FIFOs full: all outputs 0. Release reset -> mac_clr in cycle 1, done at cycle 12 (VEC_LEN=8, no skew).
- Full pass with A=1..8 and B row i = i+1 in all positions: MAC i Cout = 36*(i+1) at done, and mac_en high for exactly 8 cycles per row.
- Fill b_full[7] 5 cycles after the other FIFOs are full: controller stays in WAIT_FULL with no rden, then RUN starts on the edge after b_full[7] rises.
- Pulse start during RUN: ignored, single done. Hold start through DONE: a second CLEAR follows immediately and the second pass also yields 36*(i+1).
- Assert rst_n mid-RUN at count 4: outputs 0 asynchronously. A new start re-clears, and the results match a clean pass.
- With MAC_SEQ_CTRL_SKEW_EN: mac_en[i] starts at cycle 4+i, done at cycle 19, and results are identical to the non-skew pass.
